// File: rtl/multimode_flop_bank.sv
// multimode_flop_bank: WIDTH storage bits sharing one run-time mode
// (D / T / SR / JK). Reports which bits changed, how many changed, and a
// sticky flag for SR-mode S=R=1 conflicts. All outputs are registered.

// Per-channel next-state logic; purely combinational, one instance per bit.
module multimode_flop_bank_lane #(
  parameter int SR_CONFLICT = 0
) (
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       q,
  output logic       q_next
);

  // Next value for this bit; b is only looked at in SR and JK modes so an
  // unknown b in D/T cannot leak into the state.
  always_comb begin
    q_next = q;
    case (mode)
      2'b00: q_next = a;
      2'b01: q_next = q ^ a;
      2'b10: begin
        case ({a, b})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11: begin
            case (SR_CONFLICT)
              1:       q_next = 1'b0;
              2:       q_next = 1'b1;
              3:       q_next = ~q;
              default: q_next = q;
            endcase
          end
          default: q_next = q;
        endcase
      end
      default: begin
        case ({a, b})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   q_next = ~q;
          default: q_next = q;
        endcase
      end
    endcase
  end

endmodule

module multimode_flop_bank #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL   = {WIDTH{1'b1}},
  parameter int                 SR_CONFLICT = 0,
  parameter int                 CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             conflict_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] changed,
  output logic [CNT_W-1:0] change_cnt,
  output logic             conflict
);

  localparam logic [1:0] MODE_SR = 2'b10;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qb_q, qb_d;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic [CNT_W-1:0] change_cnt_q, change_cnt_d;
  logic             conflict_q, conflict_d;
  logic [WIDTH-1:0] lane_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    multimode_flop_bank_lane #(
      .SR_CONFLICT(SR_CONFLICT)
    ) u_lane (
      .mode   (mode),
      .a      (a[i]),
      .b      (b[i]),
      .q      (q_q[i]),
      .q_next (lane_next[i])
    );
  end

  // Next state for all registers; qb comes from the same q_d so it can
  // never lag or disagree with q.
  always_comb begin
    q_d          = enable ? lane_next : q_q;
    qb_d         = ~q_d;
    changed_d    = q_d ^ q_q;
    change_cnt_d = '0;
    for (int i = 0; i < WIDTH; i++)
      change_cnt_d = change_cnt_d + CNT_W'(changed_d[i]);
    // A fresh conflict beats a simultaneous clear.
    conflict_d = conflict_q;
    if (conflict_clr)
      conflict_d = 1'b0;
    if (enable && (mode == MODE_SR) && |(a & b))
      conflict_d = 1'b1;
  end

  // State registers; synchronous reset overrides enable and conflict_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q          <= RESET_VAL;
      qb_q         <= ~RESET_VAL;
      changed_q    <= '0;
      change_cnt_q <= '0;
      conflict_q   <= 1'b0;
    end else begin
      q_q          <= q_d;
      qb_q         <= qb_d;
      changed_q    <= changed_d;
      change_cnt_q <= change_cnt_d;
      conflict_q   <= conflict_d;
    end
  end

  assign q          = q_q;
  assign qb         = qb_q;
  assign changed    = changed_q;
  assign change_cnt = change_cnt_q;
  assign conflict   = conflict_q;

endmodule

// File: tb/tb_multimode_flop_bank.sv
// Bench for multimode_flop_bank: four instances, one per SR_CONFLICT policy,
// share the same stimulus. A directed vector table is followed by random
// traffic checked against a word-level reference model.
module tb_multimode_flop_bank;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       reset, enable, conflict_clr;
  logic [1:0] mode;
  logic [7:0] a, b;
  logic [7:0] q [NI];
  logic [7:0] qb [NI];
  logic [7:0] chg [NI];
  logic [3:0] cnt [NI];
  logic       conf [NI];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    multimode_flop_bank #(
      .WIDTH(8), .RESET_VAL(8'hFF), .SR_CONFLICT(k)
    ) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode),
      .a(a), .b(b), .conflict_clr(conflict_clr),
      .q(q[k]), .qb(qb[k]), .changed(chg[k]), .change_cnt(cnt[k]),
      .conflict(conf[k])
    );
  end

  task automatic chk(input string name, input int k, input logic [7:0] act,
                     input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s inst%0d: got 0x%02h want 0x%02h (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  // qb must be the exact complement of q on every observed cycle.
  task automatic chk_qb();
    for (int k = 0; k < NI; k++) chk("qb_eq_not_q", k, qb[k], ~q[k]);
  endtask

  // Reference: whole-word set/clear/hold/toggle masks.
  function automatic logic [7:0] ref_next(input int pol, input logic [1:0] md,
                                          input logic [7:0] cq, input logic [7:0] s,
                                          input logic [7:0] r);
    logic [7:0] set_m, clr_m, both, hold_m, both_res;
    set_m  = s & ~r;
    clr_m  = r & ~s;
    both   = s & r;
    hold_m = ~(s | r);
    if (md == 2'd0) return s;
    if (md == 2'd1) return cq ^ s;
    if (md == 2'd3) both_res = ~cq & both;
    else if (pol == 1) both_res = 8'h00;
    else if (pol == 2) both_res = both;
    else if (pol == 3) both_res = ~cq & both;
    else both_res = cq & both;
    return (cq & hold_m) | set_m | both_res;
    // clr_m bits land at 0 because they are in neither term above
  endfunction

  typedef struct {
    logic        rst, en, clr;
    logic [1:0]  md;
    logic [7:0]  va, vb;
    logic [7:0]  eq [NI];
    logic [7:0]  echg;
    logic [3:0]  ecnt;
    logic        econf;
  } vec_t;

  vec_t tbl [16];
  int   ntbl;

  function automatic vec_t mk(input logic rst, en, input logic [1:0] md,
                              input logic [7:0] va, vb, input logic clr,
                              input logic [7:0] q0, q1, q2, q3,
                              input logic [7:0] echg, input logic [3:0] ecnt,
                              input logic econf);
    vec_t v;
    v.rst = rst; v.en = en; v.md = md; v.va = va; v.vb = vb; v.clr = clr;
    v.eq[0] = q0; v.eq[1] = q1; v.eq[2] = q2; v.eq[3] = q3;
    v.echg = echg; v.ecnt = ecnt; v.econf = econf;
    return v;
  endfunction

  logic [7:0] mq [NI];
  logic [7:0] mchg [NI];
  logic       mconf [NI];
  logic [7:0] nq;

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 2'd0; a = '0; b = '0; conflict_clr = 1'b0;

    // rst en md   a      b      clr  q0..q3                         chg    cnt conf
    tbl[0]  = mk(1, 1, 2'd0, 8'h00, 8'h00, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 0, 0);
    tbl[1]  = mk(0, 1, 2'd0, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8, 0);
    tbl[2]  = mk(0, 1, 2'd0, 8'hA5, 8'h3C, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 4, 0);
    tbl[3]  = mk(0, 1, 2'd1, 8'h0F, 8'hFF, 0, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h0F, 4, 0);
    tbl[4]  = mk(0, 0, 2'd1, 8'hFF, 8'h00, 0, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h00, 0, 0);
    tbl[5]  = mk(0, 1, 2'd2, 8'h05, 8'h81, 0, 8'h2E, 8'h2E, 8'h2F, 8'h2F, 8'h84, 2, 1);
    tbl[6]  = mk(0, 1, 2'd2, 8'h10, 8'h00, 0, 8'h3E, 8'h3E, 8'h3F, 8'h3F, 8'h10, 1, 1);
    tbl[7]  = mk(0, 1, 2'd2, 8'h00, 8'h20, 0, 8'h1E, 8'h1E, 8'h1F, 8'h1F, 8'h20, 1, 1);
    tbl[8]  = mk(0, 1, 2'd2, 8'h00, 8'h00, 0, 8'h1E, 8'h1E, 8'h1F, 8'h1F, 8'h00, 0, 1);
    tbl[9]  = mk(0, 0, 2'd2, 8'h01, 8'h01, 1, 8'h1E, 8'h1E, 8'h1F, 8'h1F, 8'h00, 0, 0);
    tbl[10] = mk(0, 1, 2'd2, 8'h01, 8'h01, 1, 8'h1E, 8'h1E, 8'h1F, 8'h1E, 8'h00, 0, 1);
    tbl[11] = mk(0, 1, 2'd0, 8'h2E, 8'h00, 0, 8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h30, 2, 1);
    tbl[12] = mk(0, 1, 2'd3, 8'hFF, 8'hFF, 0, 8'hD1, 8'hD1, 8'hD1, 8'hD1, 8'hFF, 8, 1);
    tbl[13] = mk(1, 1, 2'd0, 8'h00, 8'h00, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 0, 0);
    tbl[14] = mk(0, 1, 2'd0, 8'h5A, 8'h00, 0, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'hA5, 4, 0);
    ntbl = 15;

    @(negedge clk);
    for (int i = 0; i < ntbl; i++) begin
      reset = tbl[i].rst; enable = tbl[i].en; mode = tbl[i].md;
      a = tbl[i].va; b = tbl[i].vb; conflict_clr = tbl[i].clr;
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) chk($sformatf("tbl%0d_q", i), k, q[k], tbl[i].eq[k]);
      chk($sformatf("tbl%0d_changed", i), 0, chg[0], tbl[i].echg);
      chk($sformatf("tbl%0d_cnt", i), 0, {4'h0, cnt[0]}, {4'h0, tbl[i].ecnt});
      for (int k = 0; k < NI; k++)
        chk($sformatf("tbl%0d_conflict", i), k, {7'h0, conf[k]}, {7'h0, tbl[i].econf});
      chk_qb();
    end

    // Hand sequence: reset with a pending conflict, then conflict_clr alone.
    reset = 1'b0; enable = 1'b1; mode = 2'd2; a = 8'h80; b = 8'h80; conflict_clr = 1'b0;
    @(posedge clk); #1;
    chk("seq_conf_set", 0, {7'h0, conf[0]}, 8'h01);
    reset = 1'b1; enable = 1'b1; mode = 2'd0; a = 8'h00; conflict_clr = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      chk("seq_rst_q", k, q[k], 8'hFF);
      chk("seq_rst_conf", k, {7'h0, conf[k]}, 8'h00);
      chk("seq_rst_chg", k, chg[k], 8'h00);
    end
    chk_qb();

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      reset = (i == 0) || ($urandom_range(0, 40) == 0);
      enable = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 3));
      a = 8'($urandom); b = 8'($urandom);
      conflict_clr = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < NI; k++) begin
        if (reset) begin
          mq[k] = 8'hFF; mchg[k] = 8'h00; mconf[k] = 1'b0;
        end else begin
          nq = enable ? ref_next(k, mode, mq[k], a, b) : mq[k];
          mchg[k] = nq ^ mq[k];
          mq[k] = nq;
          if (enable && mode == 2'd2 && (a & b) != 8'h00) mconf[k] = 1'b1;
          else if (conflict_clr) mconf[k] = 1'b0;
        end
      end
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) begin
        chk("rnd_q", k, q[k], mq[k]);
        chk("rnd_changed", k, chg[k], mchg[k]);
        chk("rnd_cnt", k, {4'h0, cnt[k]}, 8'($countones(mchg[k])));
        chk("rnd_conflict", k, {7'h0, conf[k]}, {7'h0, mconf[k]});
      end
      chk_qb();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/multimode_flop_bank.md
# multimode_flop_bank

Parametrised bank of WIDTH single-bit storage elements with a shared, run-time selectable mode: D, T, SR or JK. It succeeds the team's single-channel SR flip-flop. It adds a defined policy for the S=R=1 conflict, a sticky conflict flag, a guaranteed-complementary qb, and per-cycle change reporting. It sits in the sequential-primitives library and is used wherever a register field needs set/clear/toggle semantics.

## Interface
- WIDTH, 8, number of channels (≥1)
- RESET_VAL, {WIDTH{1'b1}}, value loaded into q on reset
- SR_CONFLICT, 0, per-bit SR-mode action when S=R=1: 0 hold, 1 reset-dominant, 2 set-dominant, 3 toggle
- CNT_W, $clog2(WIDTH+1), width of change_cnt (derived, not overridden)

- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high; clock clk
- enable  in  1  update qualifier; low = hold everything except conflict_clr
- mode  in  2  00 D, 01 T, 10 SR, 11 JK; sampled with enable
- a  in  WIDTH  D data / T toggle / S / J, per channel
- b  in  WIDTH  ignored in D and T / R / K, per channel
- conflict_clr  in  1  clears sticky conflict flag
- q  out  WIDTH  stored state
- qb  out  WIDTH  always ~q
- changed  out  WIDTH  bits of q that changed at the last clock edge
- change_cnt  out  CNT_W  popcount of changed
- conflict  out  1  sticky: an SR-mode S=R=1 occurred on any enabled bit

## Operation
- All outputs are registered; no combinational input-to-output path.
- Per bit i, next state when enable=1:
  - D: q<=a[i]
  - T: q<=q^a[i]
  - SR: 00 hold, 01 q<=0, 10 q<=1, 11 per SR_CONFLICT
  - JK: 00 hold, 01 q<=0, 10 q<=1, 11 toggle
- enable=0: q, qb hold; changed<=0; change_cnt<=0.
- qb is registered from the same next-value as q; qb==~q holds on every cycle including after reset. Never X, and no blocking/ordering lag.
- changed<=q_next^q; change_cnt<=popcount(q_next^q). Both are registered in the same cycle as q.
- conflict:
  - Set when enable=1, mode=10 and |(a&b).
  - Cleared by conflict_clr=1 when no new set occurs.
  - Set and clear in the same cycle: set wins.
  - conflict_clr is honoured regardless of enable.
- JK mode with a&b never sets conflict.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on q/qb/changed/change_cnt/conflict after edge N.
- A mode change takes effect on the edge where it is sampled; there are no pipeline bubbles. Back-to-back updates are allowed every cycle.
- Reset (synchronous, highest priority over enable and conflict_clr): q=RESET_VAL, qb=~RESET_VAL, changed=0, change_cnt=0, conflict=0.
- A reset asserted mid-operation discards that cycle's update. The first update is accepted on the first edge with reset=0.
- X on a/b of a bit not used by the current mode (b in D/T) must not propagate.

## Test plan
(WIDTH=8, RESET_VAL=0xFF, SR_CONFLICT=0 unless stated)
- Reset, then enable=1, mode=D, a=0x00 -> q=0x00, qb=0xFF, changed=0xFF, change_cnt=8. Next cycle a=0xA5 -> q=0xA5, qb=0x5A, changed=0xA5, change_cnt=4.
- From q=0xA5: mode=T, a=0x0F -> q=0xAA, changed=0x0F, change_cnt=4. Then enable=0 with a=0xFF -> q stays 0xAA, changed=0, change_cnt=0.
- From q=0xAA: mode=SR, a=0x05, b=0x81 -> q=0x2E, changed=0x84, change_cnt=2, conflict=1. Repeat with SR_CONFLICT=1 -> 0x2E; with 2 -> 0x2F; with 3 -> 0x2F.
- Conflict stickiness: conflict=1, then SR with a&b=0 for 3 cycles -> conflict stays 1. conflict_clr=1 with enable=0 -> conflict=0 next cycle. conflict_clr=1 together with a new SR conflict -> conflict=1.
- From q=0x2E: mode=JK, a=0xFF, b=0xFF -> q=0xD1, qb=0x2E, changed=0xFF, change_cnt=8, conflict unchanged.
- Reset asserted with enable=1, mode=D, a=0x00 and conflict=1 -> q=0xFF, qb=0x00, changed=0, change_cnt=0, conflict=0. Check qb==~q on every cycle of every scenario.
